// File: rtl/pipe_skid_latch.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and an
// optional one-entry skid buffer that registers ready_o to cut the upstream stall path.
module pipe_skid_latch #(
    parameter int                 width_p      = 32,
    parameter int                 skid_p       = 1,
    parameter logic [width_p-1:0] reset_data_p = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i,
    output logic [1:0]         count_o
);

    localparam logic skid_en_c = (skid_p != 32'sd0);

    logic               main_v_r;
    logic [width_p-1:0] main_d_r;
    logic               skid_v_r;
    logic [width_p-1:0] skid_d_r;

    logic               main_v_nx_s;
    logic [width_p-1:0] main_d_nx_s;
    logic               skid_v_nx_s;
    logic [width_p-1:0] skid_d_nx_s;

    logic               skid_v_s;
    logic               ready_s;
    logic               in_xfer_s;
    logic               out_xfer_s;

    // The skid entry only exists in skid mode; otherwise it reads as empty.
    assign skid_v_s   = skid_en_c ? skid_v_r : 1'b0;
    assign ready_s    = skid_en_c ? ~skid_v_r : (~main_v_r | ready_i);
    assign ready_o    = ready_s & ~rst_i;
    assign in_xfer_s  = v_i & ready_o;
    assign out_xfer_s = main_v_r & ready_i;

    assign v_o     = main_v_r;
    assign data_o  = main_d_r;
    assign count_o = {1'b0, main_v_r} + {1'b0, skid_v_s};

    // Next-state selection: flush beats the normal handshake update.
    always_comb begin
        main_v_nx_s = main_v_r;
        main_d_nx_s = main_d_r;
        skid_v_nx_s = skid_v_r;
        skid_d_nx_s = skid_d_r;
        if (flush_i) begin
            // Drops held entries and any incoming beat; payload registers keep their contents.
            main_v_nx_s = 1'b0;
            skid_v_nx_s = 1'b0;
        end else if (skid_en_c) begin
            if (out_xfer_s && skid_v_r) begin
                main_v_nx_s = 1'b1;
                main_d_nx_s = skid_d_r;
                skid_v_nx_s = 1'b0;
            end else if (out_xfer_s) begin
                main_v_nx_s = in_xfer_s;
                if (in_xfer_s) begin
                    main_d_nx_s = data_i;
                end else begin
                    main_d_nx_s = main_d_r;
                end
            end else if (in_xfer_s && !main_v_r) begin
                main_v_nx_s = 1'b1;
                main_d_nx_s = data_i;
            end else if (in_xfer_s) begin
                skid_v_nx_s = 1'b1;
                skid_d_nx_s = data_i;
            end else begin
                main_v_nx_s = main_v_r;
            end
        end else begin
            if (in_xfer_s) begin
                main_v_nx_s = 1'b1;
                main_d_nx_s = data_i;
            end else if (out_xfer_s) begin
                main_v_nx_s = 1'b0;
            end else begin
                main_v_nx_s = main_v_r;
            end
        end
    end

    // State registers with synchronous reset to the configured payload value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_v_r <= 1'b0;
            skid_v_r <= 1'b0;
            main_d_r <= reset_data_p;
            skid_d_r <= reset_data_p;
        end else begin
            main_v_r <= main_v_nx_s;
            skid_v_r <= skid_en_c ? skid_v_nx_s : 1'b0;
            main_d_r <= main_d_nx_s;
            skid_d_r <= skid_d_nx_s;
        end
    end

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Self-checking bench: one skid-mode and one single-entry stage, each compared
// every cycle against a queue-based model of the stage's contents.
module tb_pipe_skid_latch;
    localparam int         W    = 16;
    localparam logic [W-1:0] RD_A = 16'hDEAD;
    localparam logic [W-1:0] RD_B = 16'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, a_flush, a_v_i, a_ready_i, a_ready_o, a_v_o;
    logic [W-1:0] a_data_i, a_data_o;
    logic [1:0]   a_count_o;
    logic b_rst, b_flush, b_v_i, b_ready_i, b_ready_o, b_v_o;
    logic [W-1:0] b_data_i, b_data_o;
    logic [1:0]   b_count_o;

    pipe_skid_latch #(.width_p(W), .skid_p(1), .reset_data_p(RD_A)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush), .v_i(a_v_i), .data_i(a_data_i),
        .ready_o(a_ready_o), .v_o(a_v_o), .data_o(a_data_o), .ready_i(a_ready_i),
        .count_o(a_count_o));

    pipe_skid_latch #(.width_p(W), .skid_p(0), .reset_data_p(RD_B)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush), .v_i(b_v_i), .data_i(b_data_i),
        .ready_o(b_ready_o), .v_o(b_v_o), .data_o(b_data_o), .ready_i(b_ready_i),
        .count_o(b_count_o));

    int total = 0;
    int bad   = 0;

    // Model: FIFO contents plus the payload last presented downstream.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] la, lb;

    logic         cap_a_in, cap_a_out;
    logic [W-1:0] cap_a_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_ready_a();
        return (qa.size() < 2) && !a_rst;
    endfunction

    function automatic logic exp_ready_b();
        return ((qb.size() == 0) || b_ready_i) && !b_rst;
    endfunction

    task automatic check_outputs();
        chk("a_ready", {31'd0, a_ready_o}, {31'd0, exp_ready_a()});
        chk("a_v", {31'd0, a_v_o}, {31'd0, qa.size() > 0});
        chk("a_count", {30'd0, a_count_o}, qa.size());
        chk("a_data", {16'd0, a_data_o}, {16'd0, (qa.size() > 0) ? qa[0] : la});
        chk("b_ready", {31'd0, b_ready_o}, {31'd0, exp_ready_b()});
        chk("b_v", {31'd0, b_v_o}, {31'd0, qb.size() > 0});
        chk("b_count", {30'd0, b_count_o}, qb.size());
        chk("b_data", {16'd0, b_data_o}, {16'd0, (qb.size() > 0) ? qb[0] : lb});
    endtask

    task automatic step_models();
        logic ra, rb, outx, inx;
        ra = exp_ready_a();
        rb = exp_ready_b();
        if (a_rst) begin
            qa.delete(); la = RD_A;
        end else if (a_flush) begin
            qa.delete();
        end else begin
            outx = (qa.size() > 0) && a_ready_i;
            inx  = a_v_i && ra;
            if (outx) void'(qa.pop_front());
            if (inx) qa.push_back(a_data_i);
        end
        if (qa.size() > 0) la = qa[0];
        if (b_rst) begin
            qb.delete(); lb = RD_B;
        end else if (b_flush) begin
            qb.delete();
        end else begin
            outx = (qb.size() > 0) && b_ready_i;
            inx  = b_v_i && rb;
            if (outx) void'(qb.pop_front());
            if (inx) qb.push_back(b_data_i);
        end
        if (qb.size() > 0) lb = qb[0];
    endtask

    // One clock: settle, compare, record handshakes, advance model and DUT.
    task automatic tick();
        #1;
        check_outputs();
        cap_a_in   = a_v_i & a_ready_o;
        cap_a_out  = a_v_o & a_ready_i;
        cap_a_data = a_data_o;
        step_models();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] rcv[$];
        logic pat[5];
        int k;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        a_rst = 1'b1; a_flush = 1'b0; a_v_i = 1'b0; a_ready_i = 1'b0; a_data_i = 16'h0000;
        b_rst = 1'b1; b_flush = 1'b0; b_v_i = 1'b0; b_ready_i = 1'b0; b_data_i = 16'h0000;
        @(posedge clk);
        #1;
        qa.delete(); qb.delete(); la = RD_A; lb = RD_B;
        a_rst = 1'b0; b_rst = 1'b0;
        #1;
        chk("rst_a_v", {31'd0, a_v_o}, 32'd0);
        chk("rst_a_count", {30'd0, a_count_o}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready_o}, 32'd1);

        // Single beat passes with one cycle latency.
        a_v_i = 1'b1; a_data_i = 16'h00A5; a_ready_i = 1'b1;
        tick();
        a_v_i = 1'b0;
        chk("t1_v", {31'd0, a_v_o}, 32'd1);
        chk("t1_data", {16'd0, a_data_o}, 32'h00A5);
        chk("t1_count", {30'd0, a_count_o}, 32'd1);
        tick();
        chk("t1_v_after", {31'd0, a_v_o}, 32'd0);

        // Skid fill and drain.
        a_ready_i = 1'b0; a_v_i = 1'b1; a_data_i = 16'h0011;
        tick();
        a_data_i = 16'h0022;
        tick();
        a_v_i = 1'b0;
        chk("t2_count", {30'd0, a_count_o}, 32'd2);
        chk("t2_ready", {31'd0, a_ready_o}, 32'd0);
        chk("t2_data", {16'd0, a_data_o}, 32'h0011);
        a_ready_i = 1'b1;
        tick();
        chk("t2_data2", {16'd0, a_data_o}, 32'h0022);
        chk("t2_ready2", {31'd0, a_ready_o}, 32'd1);
        tick();
        chk("t2_empty", {31'd0, a_v_o}, 32'd0);

        // Streaming with toggling downstream ready; upstream holds refused beats.
        k = 1;
        for (int c = 0; c < 60 && rcv.size() < 8; c++) begin
            a_v_i = (k <= 8);
            a_data_i = W'(k);
            a_ready_i = pat[c % 5];
            tick();
            if (cap_a_in) k++;
            if (cap_a_out) rcv.push_back(cap_a_data);
        end
        a_v_i = 1'b0; a_ready_i = 1'b0;
        chk("t3_nrcv", rcv.size(), 32'd8);
        for (int i = 0; i < rcv.size(); i++) chk("t3_order", {16'd0, rcv[i]}, i + 1);

        // Flush with full stage and a beat offered.
        a_v_i = 1'b1; a_data_i = 16'h0033;
        tick();
        a_data_i = 16'h0044;
        tick();
        a_flush = 1'b1; a_data_i = 16'h0055;
        tick();
        a_flush = 1'b0; a_v_i = 1'b0;
        chk("t4_v", {31'd0, a_v_o}, 32'd0);
        chk("t4_count", {30'd0, a_count_o}, 32'd0);
        chk("t4_ready", {31'd0, a_ready_o}, 32'd1);
        a_ready_i = 1'b1;
        tick();
        chk("t4_v_later", {31'd0, a_v_o}, 32'd0);

        // Single-entry stall latch.
        b_ready_i = 1'b0; b_v_i = 1'b1; b_data_i = 16'h0077;
        tick();
        b_data_i = 16'h0078;
        #1;
        chk("t5_ready", {31'd0, b_ready_o}, 32'd0);
        chk("t5_hold", {16'd0, b_data_o}, 32'h0077);
        tick();
        b_ready_i = 1'b1;
        tick();
        b_v_i = 1'b0;
        chk("t5_data", {16'd0, b_data_o}, 32'h0078);
        chk("t5_v", {31'd0, b_v_o}, 32'd1);
        tick();

        // Mid-operation reset with a full skid stage.
        a_ready_i = 1'b0; a_v_i = 1'b1; a_data_i = 16'h0066;
        tick();
        a_data_i = 16'h0067;
        tick();
        a_v_i = 1'b0; a_rst = 1'b1;
        #1;
        chk("t6_ready_rst", {31'd0, a_ready_o}, 32'd0);
        tick();
        a_rst = 1'b0;
        chk("t6_v", {31'd0, a_v_o}, 32'd0);
        chk("t6_count", {30'd0, a_count_o}, 32'd0);
        chk("t6_data", {16'd0, a_data_o}, 32'h0000DEAD);
        #1;
        chk("t6_ready", {31'd0, a_ready_o}, 32'd1);

        // Randomized traffic on both stages.
        for (int c = 0; c < 400; c++) begin
            a_v_i = 1'($urandom); a_data_i = W'($urandom); a_ready_i = 1'($urandom);
            a_flush = ($urandom_range(19, 0) == 0); a_rst = ($urandom_range(59, 0) == 0);
            b_v_i = 1'($urandom); b_data_i = W'($urandom); b_ready_i = 1'($urandom);
            b_flush = ($urandom_range(19, 0) == 0); b_rst = ($urandom_range(59, 0) == 0);
            tick();
        end
        a_rst = 1'b0; a_flush = 1'b0; b_rst = 1'b0; b_flush = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
